// File: rtl/demux12_buf_if.sv
// Handshake bundle for demux12_buf: one routed input stream and two buffered output streams.
interface demux12_buf_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] d;
  logic             s;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;
  logic             y0_valid;
  logic             y1_valid;
  logic             y0_ready;
  logic             y1_ready;
  logic [1:0]       cnt0;
  logic [1:0]       cnt1;

  modport master (
    output d, s, in_valid, y0_ready, y1_ready,
    input  in_ready, y0, y1, y0_valid, y1_valid, cnt0, cnt1
  );

  modport slave (
    input  d, s, in_valid, y0_ready, y1_ready,
    output in_ready, y0, y1, y0_valid, y1_valid, cnt0, cnt1
  );
endinterface

// File: rtl/demux12_buf.sv
// 1-to-2 demultiplexer with an independent 2-entry FIFO per output.
// Routing is decided at the accept edge; each output shows its registered head word.
module demux12_buf #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  demux12_buf_if.slave bus
);

  logic [WIDTH-1:0] mem_q  [2][2];
  logic [WIDTH-1:0] mem_d  [2][2];
  logic [WIDTH-1:0] head_q [2];
  logic [WIDTH-1:0] head_d [2];
  logic [1:0]       cnt_q  [2];
  logic [1:0]       cnt_d  [2];
  logic [1:0]       wptr_q;
  logic [1:0]       wptr_d;
  logic [1:0]       rptr_q;
  logic [1:0]       rptr_d;
  logic [1:0]       push_s;
  logic [1:0]       pop_s;
  logic [1:0]       y_ready_s;
  logic             in_ready_s;
  logic             accept_s;

  // Readiness looks only at the addressed queue's stored occupancy, never at the sinks.
  assign in_ready_s = rst_n & (bus.s ? (cnt_q[1] != 2'd2) : (cnt_q[0] != 2'd2));
  assign accept_s   = bus.in_valid & in_ready_s;
  assign push_s     = {accept_s & bus.s, accept_s & ~bus.s};
  assign y_ready_s  = {bus.y1_ready, bus.y0_ready};
  assign pop_s      = {y_ready_s[1] & (cnt_q[1] != 2'd0), y_ready_s[0] & (cnt_q[0] != 2'd0)};

  // Next-state for both circular buffers, including the head word they will present.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    for (int k = 0; k < 2; k++) begin
      if (push_s[k]) begin
        mem_d[k][wptr_q[k]] = bus.d;
        wptr_d[k]           = ~wptr_q[k];
      end else begin
        wptr_d[k] = wptr_q[k];
      end
      if (pop_s[k]) begin
        rptr_d[k] = ~rptr_q[k];
      end else begin
        rptr_d[k] = rptr_q[k];
      end
      case ({push_s[k], pop_s[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + 2'd1;
        2'b01:   cnt_d[k] = cnt_q[k] - 2'd1;
        default: cnt_d[k] = cnt_q[k];
      endcase
      // Head is precomputed so the output is a plain flop that reads zero when empty.
      if (cnt_d[k] != 2'd0) begin
        head_d[k] = mem_d[k][rptr_d[k]];
      end else begin
        head_d[k] = {WIDTH{1'b0}};
      end
    end
  end

  // Queue state, pointers and registered head words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mem_q[k][0] <= {WIDTH{1'b0}};
        mem_q[k][1] <= {WIDTH{1'b0}};
        head_q[k]   <= {WIDTH{1'b0}};
        cnt_q[k]    <= 2'd0;
      end
      wptr_q <= 2'b00;
      rptr_q <= 2'b00;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  assign bus.in_ready = in_ready_s;
  assign bus.y0       = head_q[0];
  assign bus.y1       = head_q[1];
  assign bus.y0_valid = (cnt_q[0] != 2'd0);
  assign bus.y1_valid = (cnt_q[1] != 2'd0);
  assign bus.cnt0     = cnt_q[0];
  assign bus.cnt1     = cnt_q[1];

endmodule

// File: tb/tb_demux12_buf.sv
// Self-checking bench for demux12_buf: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_demux12_buf;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [WIDTH-1:0] mq0[$];
  logic [WIDTH-1:0] mq1[$];

  demux12_buf_if #(.WIDTH(WIDTH)) bus ();

  demux12_buf #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against what the queues say must be visible now.
  task automatic check_model();
    logic [WIDTH-1:0] e0;
    logic [WIDTH-1:0] e1;
    logic             er;
    e0 = (mq0.size() != 0) ? mq0[0] : '0;
    e1 = (mq1.size() != 0) ? mq1[0] : '0;
    er = rst_n && (bus.s ? (mq1.size() < 2) : (mq0.size() < 2));
    cmp("model_y0",       32'(bus.y0),       32'(e0));
    cmp("model_y1",       32'(bus.y1),       32'(e1));
    cmp("model_y0_valid", 32'(bus.y0_valid), 32'(mq0.size() != 0));
    cmp("model_y1_valid", 32'(bus.y1_valid), 32'(mq1.size() != 0));
    cmp("model_cnt0",     32'(bus.cnt0),     32'(mq0.size()));
    cmp("model_cnt1",     32'(bus.cnt1),     32'(mq1.size()));
    cmp("model_in_ready", 32'(bus.in_ready), 32'(er));
  endtask

  // One clock: check, predict the edge's accept/pops, let the edge happen, update the model.
  task automatic tick();
    logic acc;
    logic p0;
    logic p1;
    logic sel;
    logic [WIDTH-1:0] dv;
    #1;
    check_model();
    sel = bus.s;
    dv  = bus.d;
    acc = rst_n && bus.in_valid && (sel ? (mq1.size() < 2) : (mq0.size() < 2));
    p0  = rst_n && bus.y0_ready && (mq0.size() != 0);
    p1  = rst_n && bus.y1_ready && (mq1.size() != 0);
    @(posedge clk);
    if (p0) void'(mq0.pop_front());
    if (p1) void'(mq1.pop_front());
    if (acc) begin
      if (sel) mq1.push_back(dv);
      else     mq0.push_back(dv);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic sel, input logic [WIDTH-1:0] dv,
                       input logic r0, input logic r1);
    bus.in_valid = v;
    bus.s        = sel;
    bus.d        = dv;
    bus.y0_ready = r0;
    bus.y1_ready = r1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    mq0.delete();
    mq1.delete();
    cmp("rst_cnt0",  32'(bus.cnt0),     32'd0);
    cmp("rst_cnt1",  32'(bus.cnt1),     32'd0);
    cmp("rst_v0",    32'(bus.y0_valid), 32'd0);
    cmp("rst_v1",    32'(bus.y1_valid), 32'd0);
    cmp("rst_y0",    32'(bus.y0),       32'd0);
    cmp("rst_y1",    32'(bus.y1),       32'd0);
    cmp("rst_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    // Hold reset across edges with in_valid high: nothing may be accepted.
    tick();
    tick();
    cmp("rst_hold_cnt0", 32'(bus.cnt0), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Route to both outputs with sinks ready.
    drive(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    tick();
    cmp("route_y0",  32'(bus.y0),       32'h0000_00A5);
    cmp("route_v0",  32'(bus.y0_valid), 32'd1);
    drive(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
    tick();
    cmp("route_y1",  32'(bus.y1),       32'h0000_003C);
    cmp("route_v0b", 32'(bus.y0_valid), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    cmp("route_v1b", 32'(bus.y1_valid), 32'd0);

    // Fill queue 0 under back-pressure, then drain while the third word waits.
    drive(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
    #1;
    cmp("full_cnt0",  32'(bus.cnt0),     32'd2);
    cmp("full_ready", 32'(bus.in_ready), 32'd0);
    tick();
    cmp("full_hold",  32'(bus.cnt0),     32'd2);

    // Independence: queue 0 stalled, queue 1 still flows.
    drive(1'b1, 1'b1, 8'h44, 1'b0, 1'b1);
    #1;
    cmp("ind_ready", 32'(bus.in_ready), 32'd1);
    tick();
    cmp("ind_y1",   32'(bus.y1),   32'h0000_0044);
    cmp("ind_cnt0", 32'(bus.cnt0), 32'd2);

    // Re-route a stalled word by flipping s before the edge.
    drive(1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
    #1;
    cmp("rr_stall", 32'(bus.in_ready), 32'd0);
    bus.s = 1'b1;
    tick();
    cmp("rr_y1",   32'(bus.y1),   32'h0000_0077);
    cmp("rr_cnt0", 32'(bus.cnt0), 32'd2);

    // Drain queue 0 in order while 0x33 is still offered.
    drive(1'b1, 1'b0, 8'h33, 1'b1, 1'b1);
    tick();
    cmp("drain_y0a", 32'(bus.y0), 32'h0000_0022);
    tick();
    cmp("drain_y0b", 32'(bus.y0), 32'h0000_0033);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    cmp("drain_v0", 32'(bus.y0_valid), 32'd0);

    // Simultaneous push/pop on a single-entry queue.
    drive(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 8'h66, 1'b0, 1'b1);
    tick();
    cmp("pp_cnt1", 32'(bus.cnt1), 32'd1);
    cmp("pp_y1",   32'(bus.y1),   32'h0000_0066);

    // Async reset between edges with words in both queues.
    drive(1'b1, 1'b0, 8'h81, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 8'h82, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    cmp("pre_rst_cnt0", 32'(bus.cnt0), 32'd2);
    cmp("pre_rst_cnt1", 32'(bus.cnt1), 32'd1);
    do_reset();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0));
      if (i == 1500) begin
        do_reset();
      end else begin
        tick();
      end
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux12_buf.md
DEMUX12_BUF -- requirements
Module: demux12_buf

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, data word width in bits (legal 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port d, input, WIDTH bits: input data word.
REQ-005 The block SHALL have port s, input, 1 bit: destination select, 0 to output 0, 1 to output 1.
REQ-006 The block SHALL have port in_valid, input, 1 bit: d/s hold a word to transfer.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the word this cycle.
REQ-008 The block SHALL have ports y0 and y1, output, WIDTH bits each: head data word of each output queue.
REQ-009 The block SHALL have ports y0_valid and y1_valid, output, 1 bit each: the matching queue is non-empty.
REQ-010 The block SHALL have ports y0_ready and y1_ready, input, 1 bit each: the sink takes the head word this cycle.
REQ-011 The block SHALL have ports cnt0 and cnt1, output, 2 bits each: occupancy of each queue, 0..2.

Function
REQ-012 Each output SHALL own an independent 2-entry FIFO queue; words leave each queue in acceptance order.
REQ-013 in_ready SHALL be combinational: 1 iff the queue addressed by the current s has cnt < 2; it SHALL NOT depend on y0_ready/y1_ready (no same-cycle pass-through).
REQ-014 Accept = in_valid & in_ready at a rising edge; the word d SHALL be pushed into queue s as sampled on that edge.
REQ-015 A change of s while in_valid=1 and in_ready=0 SHALL re-route the pending word; routing is decided only at the accept edge.
REQ-016 Pop on queue k = yk_valid & yk_ready at a rising edge; the head entry SHALL be removed.
REQ-017 yk_valid SHALL equal (cntk != 0); yk SHALL show the head entry, registered, and SHALL read 0 when the queue is empty.
REQ-018 Latency: a word accepted at edge N SHALL appear on yk with yk_valid=1 after edge N when queue k was empty; minimum latency one cycle.
REQ-019 Simultaneous push and pop on the same queue SHALL leave cnt unchanged, with the order preserved; on cnt=1 the pushed word becomes head after the edge.
REQ-020 Push with no pop SHALL increment cnt; pop with no push SHALL decrement cnt; cnt SHALL never exceed 2 or wrap below 0.
REQ-021 A pop with yk_valid=0 SHALL be ignored; in_valid=0 SHALL never modify state, whatever the value of s or d.
REQ-022 Queues SHALL be internally 2-entry circular buffers with 1-bit read/write pointers that wrap 1 to 0; the pointers are not visible on the ports.
REQ-023 Queue 0 and queue 1 SHALL never interact: back-pressure on one output SHALL NOT stall words routed to the other.

Reset
REQ-024 rst_n=0 SHALL asynchronously clear both queues: cnt0=cnt1=0, y0_valid=y1_valid=0, y0=y1=0, pointers=0, stored data discarded.
REQ-025 While rst_n=0, in_ready SHALL read 0 and no accept or pop SHALL occur.
REQ-026 Reset asserted mid-transfer SHALL drop all in-flight words; after rst_n rises, the first accept SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-027 Route: WIDTH=8, reset, then present d=0xA5,s=0 and d=0x3C,s=1 with both sinks ready -> y0=0xA5 and y1=0x3C, each valid for one cycle, one cycle after its accept.
REQ-028 Full/back-pressure: y0_ready=0, send 0x11,0x22,0x33 to s=0 -> cnt0=2, in_ready=0 on the third word; raise y0_ready -> 0x11,0x22,0x33 out in order.
REQ-029 Independence: queue 0 full and stalled, send 0x44 with s=1 -> in_ready=1, y1=0x44 valid next cycle, cnt0 stays 2.
REQ-030 Simultaneous push/pop: cnt1=1 (head 0x55), y1_ready=1 and push 0x66 -> cnt1 stays 1, y1=0x66 next cycle.
REQ-031 Re-route while stalled: queue 0 full, in_valid=1,s=0 (stalled), switch s to 1 -> word accepted into queue 1 that edge.
REQ-032 Async reset: queues hold 2 and 1 words, pulse rst_n low between edges -> all cnt=0, all valid=0, y0=y1=0 immediately, before the next clk edge.
